// File: rtl/button_gesture.sv
// button_gesture: per-button classifier turning debounced press/release activity
// into single-cycle short, double, long and auto-repeat events.
module button_gesture #(
    parameter int NUM        = 4,
    parameter int LONG_CYC   = 75000000,
    parameter int REPEAT_CYC = 15000000,
    parameter int DBL_CYC    = 45000000
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [NUM-1:0] button_hold_i,
    input  logic [NUM-1:0] button_press_i,
    input  logic [NUM-1:0] button_release_i,
    output logic [NUM-1:0] short_o,
    output logic [NUM-1:0] double_o,
    output logic [NUM-1:0] long_o,
    output logic [NUM-1:0] repeat_o,
    output logic [NUM-1:0] busy_o
);
    typedef enum logic [2:0] {IDLE, DOWN, LONG, WAIT_DBL, SWALLOW} state_t;

    for (genvar i = 0; i < NUM; i++) begin : g_btn
        state_t      state_q, state_d;
        logic [31:0] cnt_q, cnt_d;
        logic        short_q, short_d, pend_q, pend_d, hit_q, hit_d, double_q, double_d;
        logic        long_q, long_d, repeat_q, repeat_d, busy_q, busy_d;
        logic        press, rel;

        assign press = button_press_i[i];
        assign rel   = button_release_i[i] | ~button_hold_i[i];

        always_comb begin
            state_d  = state_q;
            cnt_d    = cnt_q;
            short_d  = pend_q;
            pend_d   = 1'b0;
            hit_d    = 1'b0;
            double_d = hit_q;
            long_d   = 1'b0;
            repeat_d = 1'b0;
            busy_d   = state_q != IDLE;
            case (state_q)
                IDLE: begin
                    state_d = press ? DOWN : IDLE;
                    cnt_d   = press ? 32'd1 : cnt_q;
                end
                DOWN: begin
                    // a release on the threshold cycle still counts as a short click
                    if (rel) begin
                        pend_d  = DBL_CYC == 0;
                        state_d = DBL_CYC == 0 ? IDLE : WAIT_DBL;
                        cnt_d   = 32'd1;
                    end else if (cnt_q == 32'(LONG_CYC)) begin
                        long_d  = 1'b1;
                        state_d = LONG;
                        cnt_d   = 32'd1;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                LONG: begin
                    if (rel) begin
                        state_d = IDLE;
                    end else if (cnt_q == 32'(REPEAT_CYC)) begin
                        repeat_d = 1'b1;
                        cnt_d    = 32'd1;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                WAIT_DBL: begin
                    // window expiry and a coincident press: confirm the click, start afresh
                    if (cnt_q == 32'(DBL_CYC)) begin
                        short_d = 1'b1;
                        state_d = press ? DOWN : IDLE;
                        cnt_d   = 32'd1;
                    end else if (press) begin
                        hit_d   = 1'b1;
                        state_d = SWALLOW;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                SWALLOW: state_d = rel ? IDLE : SWALLOW;
                default: state_d = IDLE;
            endcase
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q  <= IDLE;
                cnt_q    <= '0;
                short_q  <= 1'b0;
                pend_q   <= 1'b0;
                hit_q    <= 1'b0;
                double_q <= 1'b0;
                long_q   <= 1'b0;
                repeat_q <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                short_q  <= short_d;
                pend_q   <= pend_d;
                hit_q    <= hit_d;
                double_q <= double_d;
                long_q   <= long_d;
                repeat_q <= repeat_d;
                busy_q   <= busy_d;
            end
        end

        assign short_o[i]  = short_q;
        assign double_o[i] = double_q;
        assign long_o[i]   = long_q;
        assign repeat_o[i] = repeat_q;
        assign busy_o[i]   = busy_q;
    end
endmodule
